control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 i_clk  input  1  system clock; all state changes on rising edge.
REQ-002 i_rstn  input  1  reset, asynchronous, active-low.
REQ-003 i_ir  input  8  instruction register contents; [7:4] opcode, [3:0] operand.
REQ-004 i_flags  input  2  registered ALU flags; [1] carry, [0] zero.
REQ-005 o_pc_cntn, o_pc_den, o_pc_din  output  1 each  program counter increment, bus-drive and load strobes; active-low.
REQ-006 o_mar_din  output  1  memory address register load; active-low.
REQ-007 o_ram_den, o_ram_din  output  1 each  RAM bus-drive and write; active-low.
REQ-008 o_ir_din, o_ir_den  output  1 each  IR load and operand-nibble bus-drive; active-low.
REQ-009 o_a_din, o_a_den, o_b_din  output  1 each  A-register load/drive and B-register load; active-low.
REQ-010 o_alu_den, o_flags_din, o_out_din  output  1 each  ALU drive, flag capture and output-register load; active-low.
REQ-011 o_alu_sub  output  1  ALU subtract mode; active-high.
REQ-012 o_halt  output  1  sequencer halted; active-high.

Function
REQ-013 The state register SHALL hold one of IDLE, T0, T1, T2, T3, T4, HALT.
REQ-014 Transitions SHALL be IDLE->T0, T0->T1, T1->T2, Tn->Tn+1 while steps remain, last step->T0, HALT->HALT.
REQ-015 Outputs SHALL be decoded combinationally from the state, i_ir[7:4] and i_flags; only the strobes listed below go low, all others stay high.
REQ-016 T0 SHALL assert pc_den and mar_din; T1 SHALL assert ram_den, ir_din and pc_cntn.
REQ-017 Execute steps (T2/T3/T4) SHALL be:
- 0 NOP: T2 none.
- 1 LDA: T2 ir_den+mar_din; T3 ram_den+a_din.
- 2 ADD: T2 ir_den+mar_din; T3 ram_den+b_din; T4 alu_den+a_din+flags_din.
- 3 SUB: as ADD, with o_alu_sub=1 during T4 only.
- 4 STA: T2 ir_den+mar_din; T3 a_den+ram_din.
- 5 LDI: T2 ir_den+a_din.
- 6 JMP: T2 ir_den+pc_din.
- 7 JC / 8 JZ: T2 ir_den+pc_din if carry / zero is 1, otherwise none.
- E OUT: T2 a_den+out_din.
- F HLT: T2 none, next state HALT.
REQ-018 Undefined opcodes (9-D) SHALL execute as NOP.
REQ-019 Instruction length SHALL be variable: the state after the last listed step is T0, with no idle T-states.
REQ-020 Conditional-jump flags SHALL be sampled combinationally during T2 only.
REQ-021 At most one *_den SHALL be low in any cycle; pc_cntn and pc_din SHALL never be low together.
REQ-022 In HALT all strobes SHALL be high, o_alu_sub=0 and o_halt=1 until reset.

Reset
REQ-023 While i_rstn=0, state SHALL be IDLE, every active-low strobe 1, o_alu_sub=0 and o_halt=0, independent of i_clk.
REQ-024 IDLE SHALL last exactly one clock after reset release and assert no strobes.
REQ-025 Reset asserted mid-instruction SHALL abandon the instruction; no partial step resumes.

Structure
REQ-026 Package cpu_pkg SHALL hold the opcode enum (4-bit), state enum and a packed control-word struct with one field per strobe.
REQ-027 Sub-module microcode_rom SHALL map {state, opcode, flags} to the control word combinationally; control_sequencer SHALL own only the state register and next-state logic.

Verification
REQ-028 Reset release with i_ir=0x00: IDLE, then T0 (pc_den, mar_din low), T1 (ram_den, ir_din, pc_cntn low), T2 (none), then T0.
REQ-029 i_ir=0x2F: T2 ir_den+mar_din, T3 ram_den+b_din, T4 alu_den+a_din+flags_din with alu_sub=0; repeating with 0x3F gives alu_sub=1 in T4 only.
REQ-030 i_ir=0x74: flags=2'b10 gives ir_den+pc_din in T2; flags=2'b00 gives no strobes in T2, then T0.
REQ-031 i_ir=0xF0: HALT entered after T2 with o_halt=1 and all strobes high for 20 clocks; an i_rstn pulse returns to IDLE.
REQ-032 i_rstn low during T3 of 0x2F: all strobes high within the same cycle (no clock edge); after release, IDLE then T0.
REQ-033 Random opcodes and flags for 1000 instructions: REQ-021 invariant holds every cycle; opcodes 0x9-0xD show NOP timing.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the control sequencer: opcodes, T-states and the control word.
// exec_steps gives how many execute T-states (T2..T4) an opcode occupies.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5,
    ST_HALT = 3'd6
  } state_t;

  typedef struct packed {
    logic pc_cntn;
    logic pc_den;
    logic pc_din;
    logic mar_din;
    logic ram_den;
    logic ram_din;
    logic ir_din;
    logic ir_den;
    logic a_din;
    logic a_den;
    logic b_din;
    logic alu_den;
    logic flags_din;
    logic out_din;
    logic alu_sub;
    logic halt;
  } ctrl_word_t;

  localparam int CW_W = $bits(ctrl_word_t);

  // Every active-low strobe high, alu_sub and halt low.
  localparam ctrl_word_t CW_NONE = 16'hFFFC;

  // Undefined opcodes fall through to the single-step NOP timing.
  function automatic logic [1:0] exec_steps(input logic [3:0] op);
    case (op)
      OP_LDA, OP_STA: exec_steps = 2'd2;
      OP_ADD, OP_SUB: exec_steps = 2'd3;
      default:        exec_steps = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: {state, opcode, flags} -> control word, zero latency.
// No flow control; flags matter only in T2 for conditional jumps.
module microcode_rom
  import cpu_pkg::*;
(
  input  logic [2:0]      i_state,
  input  logic [3:0]      i_opcode,
  input  logic [1:0]      i_flags,
  output logic [CW_W-1:0] o_cw
);

  ctrl_word_t w_cw;

  always_comb begin
    w_cw = CW_NONE;
    case (i_state)
      ST_T0: begin
        w_cw.pc_den  = 1'b0;
        w_cw.mar_din = 1'b0;
      end
      ST_T1: begin
        w_cw.ram_den = 1'b0;
        w_cw.ir_din  = 1'b0;
        w_cw.pc_cntn = 1'b0;
      end
      ST_T2: begin
        case (i_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            w_cw.ir_den  = 1'b0;
            w_cw.mar_din = 1'b0;
          end
          OP_LDI: begin
            w_cw.ir_den = 1'b0;
            w_cw.a_din  = 1'b0;
          end
          OP_JMP: begin
            w_cw.ir_den = 1'b0;
            w_cw.pc_din = 1'b0;
          end
          OP_JC: if (i_flags[1]) begin
            w_cw.ir_den = 1'b0;
            w_cw.pc_din = 1'b0;
          end
          OP_JZ: if (i_flags[0]) begin
            w_cw.ir_den = 1'b0;
            w_cw.pc_din = 1'b0;
          end
          OP_OUT: begin
            w_cw.a_den   = 1'b0;
            w_cw.out_din = 1'b0;
          end
          default: ;
        endcase
      end
      ST_T3: begin
        case (i_opcode)
          OP_LDA: begin
            w_cw.ram_den = 1'b0;
            w_cw.a_din   = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            w_cw.ram_den = 1'b0;
            w_cw.b_din   = 1'b0;
          end
          OP_STA: begin
            w_cw.a_den   = 1'b0;
            w_cw.ram_din = 1'b0;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
          w_cw.alu_den   = 1'b0;
          w_cw.a_din     = 1'b0;
          w_cw.flags_din = 1'b0;
          w_cw.alu_sub   = (i_opcode == OP_SUB);
        end
      end
      ST_HALT: w_cw.halt = 1'b1;
      default: ;
    endcase
  end

  assign o_cw = w_cw;

endmodule

// File: rtl/control_sequencer.sv
// T-state sequencer: owns the state register and next-state logic; strobes come
// combinationally from microcode_rom in the same cycle. No backpressure; HALT is sticky until reset.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [7:0] i_ir,
  input  logic [1:0] i_flags,
  output logic       o_pc_cntn,
  output logic       o_pc_den,
  output logic       o_pc_din,
  output logic       o_mar_din,
  output logic       o_ram_den,
  output logic       o_ram_din,
  output logic       o_ir_din,
  output logic       o_ir_den,
  output logic       o_a_din,
  output logic       o_a_den,
  output logic       o_b_din,
  output logic       o_alu_den,
  output logic       o_flags_din,
  output logic       o_out_din,
  output logic       o_alu_sub,
  output logic       o_halt
);

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      w_op;
  logic [1:0]      w_steps;
  logic [CW_W-1:0] w_cw_bits;
  ctrl_word_t      w_cw;
  logic            w_unused_operand;

  assign w_op    = i_ir[7:4];
  assign w_steps = exec_steps(w_op);
  // The operand nibble reaches the bus through the IR itself, not through here.
  assign w_unused_operand = ^i_ir[3:0];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: w_next = ST_T0;
      ST_T0:   w_next = ST_T1;
      ST_T1:   w_next = ST_T2;
      ST_T2: begin
        if (w_op == OP_HLT)       w_next = ST_HALT;
        else if (w_steps > 2'd1)  w_next = ST_T3;
        else                      w_next = ST_T0;
      end
      ST_T3:   w_next = (w_steps > 2'd2) ? ST_T4 : ST_T0;
      ST_T4:   w_next = ST_T0;
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_IDLE;
    endcase
  end

  microcode_rom u_rom (
    .i_state  (r_state),
    .i_opcode (w_op),
    .i_flags  (i_flags),
    .o_cw     (w_cw_bits)
  );

  assign w_cw = ctrl_word_t'(w_cw_bits);

  assign o_pc_cntn   = w_cw.pc_cntn;
  assign o_pc_den    = w_cw.pc_den;
  assign o_pc_din    = w_cw.pc_din;
  assign o_mar_din   = w_cw.mar_din;
  assign o_ram_den   = w_cw.ram_den;
  assign o_ram_din   = w_cw.ram_din;
  assign o_ir_din    = w_cw.ir_din;
  assign o_ir_den    = w_cw.ir_den;
  assign o_a_din     = w_cw.a_din;
  assign o_a_den     = w_cw.a_den;
  assign o_b_din     = w_cw.b_din;
  assign o_alu_den   = w_cw.alu_den;
  assign o_flags_din = w_cw.flags_din;
  assign o_out_din   = w_cw.out_din;
  assign o_alu_sub   = w_cw.alu_sub;
  assign o_halt      = w_cw.halt;

endmodule
